// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the register file with scoreboard.
// Holds register-count, index-width and counter-width constants next to
// the read-source (RDSRC_*) codes used by the operand read muxes.
package regfile_sb_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t CNT_ZERO = '0;
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    // Where a source operand value comes from.
    typedef enum logic [1:0] {
        RDSRC_ZERO   = 2'd0,
        RDSRC_ARRAY  = 2'd1,
        RDSRC_BYPASS = 2'd2
    } rdsrc_e;

    // x0 always reads zero; otherwise the bypass wins over the array.
    function automatic rdsrc_e rd_src(input reg_idx_t rs, input logic byp);
        if (rs == '0) begin
            return RDSRC_ZERO;
        end else if (byp) begin
            return RDSRC_BYPASS;
        end else begin
            return RDSRC_ARRAY;
        end
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb. The master side is the pipeline
// (decode issues, writeback writes); the slave side is the register file.
interface regfile_sb_if;
    import regfile_sb_pkg::*;

    // Decode stage
    logic     issue_d;
    reg_idx_t rs1_d;
    logic     rs1_used_d;
    reg_idx_t rs2_d;
    logic     rs2_used_d;
    logic     rd_write_d;
    reg_idx_t rd_d;
    data_t    rs1_data_d;
    data_t    rs2_data_d;
    logic     stall_d;

    // Writeback stage
    logic     rd_write_w;
    reg_idx_t rd_w;
    data_t    rd_data_w;

    // Status
    logic     busy;

    modport master (
        output issue_d, rs1_d, rs1_used_d, rs2_d, rs2_used_d,
        output rd_write_d, rd_d,
        output rd_write_w, rd_w, rd_data_w,
        input  rs1_data_d, rs2_data_d, stall_d, busy
    );

    modport slave (
        input  issue_d, rs1_d, rs1_used_d, rs2_d, rs2_used_d,
        input  rd_write_d, rd_d,
        input  rd_write_w, rd_w, rd_data_w,
        output rs1_data_d, rs2_data_d, stall_d, busy
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating 2-bit counter per register,
// decode stall generation and the busy flag.
// Optional macro RF_WB_BYPASS_EN lets a reader whose only outstanding
// write is landing this cycle take the writeback data instead of stalling.
module rf_scoreboard
    import regfile_sb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issue,
    input  reg_idx_t rs1,
    input  logic     rs1_used,
    input  reg_idx_t rs2,
    input  logic     rs2_used,
    input  logic     rd_write_d,
    input  reg_idx_t rd_d,
    input  logic     rd_write_w,
    input  reg_idx_t rd_w,
    output logic     stall,
    output logic     busy,
    output logic     rs1_byp,
    output logic     rs2_byp
);

    cnt_t cnt   [1:NUM_REGS-1];
    cnt_t cnt_d [1:NUM_REGS-1];
    cnt_t cnt_v [0:NUM_REGS-1];
    logic accept;
    logic haz1;
    logic haz2;

    // Flat view of the counters with x0 pinned at zero for indexed lookup.
    always_comb begin
        cnt_v[0] = CNT_ZERO;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_v[i] = cnt[i];
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Bypass only when the write landing now is the last one outstanding.
    assign rs1_byp = rd_write_w && (rd_w == rs1) && (rs1 != '0) && (cnt_v[rs1] == CNT_ONE);
    assign rs2_byp = rd_write_w && (rd_w == rs2) && (rs2 != '0) && (cnt_v[rs2] == CNT_ONE);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    // Hazard detection and stall; an idle decode never stalls.
    always_comb begin
        haz1   = rs1_used && (rs1 != '0) && (cnt_v[rs1] != CNT_ZERO) && !rs1_byp;
        haz2   = rs2_used && (rs2 != '0) && (cnt_v[rs2] != CNT_ZERO) && !rs2_byp;
        stall  = issue && (haz1 || haz2);
        accept = issue && !stall;
    end

    // Next counter values: saturating inc/dec, simultaneous inc+dec cancels.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc      = accept && rd_write_d && (rd_d == reg_idx_t'(i));
            dec      = rd_write_w && (rd_w == reg_idx_t'(i));
            cnt_d[i] = cnt[i];
            if (inc && !dec && (cnt[i] != CNT_MAX)) begin
                cnt_d[i] = cnt[i] + CNT_ONE;
            end else if (dec && !inc && (cnt[i] != CNT_ZERO)) begin
                cnt_d[i] = cnt[i] - CNT_ONE;
            end
        end
    end

    // Counter state, cleared asynchronously so reset drops every pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    // Busy reflects registered counter state only.
    always_comb begin
        busy = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy = busy | (cnt[i] != CNT_ZERO);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file x0..x31 with a pending-write scoreboard for an in-order
// pipeline. Storage and the zero-latency operand read muxes live here; the
// counters, stall and busy logic live in rf_scoreboard.
// Optional macro RF_WB_BYPASS_EN enables the writeback-to-decode bypass.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    data_t regs    [1:NUM_REGS-1];
    data_t regs_v  [0:NUM_REGS-1];
    logic  rs1_byp;
    logic  rs2_byp;
    logic  stall;
    logic  busy;

    rf_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (bus.issue_d),
        .rs1        (bus.rs1_d),
        .rs1_used   (bus.rs1_used_d),
        .rs2        (bus.rs2_d),
        .rs2_used   (bus.rs2_used_d),
        .rd_write_d (bus.rd_write_d),
        .rd_d       (bus.rd_d),
        .rd_write_w (bus.rd_write_w),
        .rd_w       (bus.rd_w),
        .stall      (stall),
        .busy       (busy),
        .rs1_byp    (rs1_byp),
        .rs2_byp    (rs2_byp)
    );

    // Register storage; writes to x0 are dropped, reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.rd_write_w && (bus.rd_w != '0)) begin
            regs[bus.rd_w] <= bus.rd_data_w;
        end
    end

    // Flat view of storage with x0 hardwired to zero.
    always_comb begin
        regs_v[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_v[i] = regs[i];
        end
    end

    // Operand read muxes: zero, array or writeback bypass.
    always_comb begin
        bus.rs1_data_d = regs_v[bus.rs1_d];
        bus.rs2_data_d = regs_v[bus.rs2_d];
        case (rd_src(bus.rs1_d, rs1_byp))
            RDSRC_ZERO:   bus.rs1_data_d = '0;
            RDSRC_BYPASS: bus.rs1_data_d = bus.rd_data_w;
            default:      bus.rs1_data_d = regs_v[bus.rs1_d];
        endcase
        case (rd_src(bus.rs2_d, rs2_byp))
            RDSRC_ZERO:   bus.rs2_data_d = '0;
            RDSRC_BYPASS: bus.rs2_data_d = bus.rd_data_w;
            default:      bus.rs2_data_d = regs_v[bus.rs2_d];
        endcase
    end

    assign bus.stall_d = stall;
    assign bus.busy    = busy;

endmodule
